// File: rtl/pulse_checker_pkg.sv
// Shared constants, error codes and state encoding for the BIST pulse checker.
package pulse_checker_pkg;

    localparam int N_MAX       = 8;
    localparam int M_MAX       = 9;
    localparam int LOW_LEN_DEF = 1;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_SHORT   = 3'd1;
    localparam logic [2:0] ERR_LONG    = 3'd2;
    localparam logic [2:0] ERR_GAP     = 3'd3;
    localparam logic [2:0] ERR_COUNT   = 3'd4;
    localparam logic [2:0] ERR_PROTO   = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_e;

endpackage

// File: rtl/counter_4b.sv
// 4-bit saturating up-counter with synchronous clear and enable.
module counter_4b (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [3:0] cnt_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pulse_checker.sv
// Receive-side monitor that checks the BIST generator burst pattern.
module pulse_checker
    import pulse_checker_pkg::*;
#(
    parameter int N_HIGH   = N_MAX,
    parameter int N_BURSTS = M_MAX + 1,
    parameter int LOW_LEN  = LOW_LEN_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pulse_in,
    input  logic       running_in,
    input  logic       bist_end_in,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic [2:0] err_code,
    output logic [3:0] burst_cnt
);

    localparam int RCW = $clog2(N_HIGH + 2);
    localparam int GCW = $clog2(LOW_LEN + 2);
    localparam int TOW = $clog2(TIMEOUT + 1);

    localparam logic [RCW-1:0] RC_ONE = RCW'(1);
    localparam logic [RCW-1:0] RC_MIN = RCW'(N_HIGH);
    localparam logic [RCW-1:0] RC_MAX = RCW'(N_HIGH + 1);
    localparam logic [GCW-1:0] GC_ONE = GCW'(1);
    localparam logic [GCW-1:0] GC_LIM = GCW'(LOW_LEN);
    localparam logic [GCW-1:0] GC_MAX = GCW'(LOW_LEN + 1);
    localparam logic [TOW-1:0] TO_LIM = TOW'(TIMEOUT);

    state_e         state_q, state_d;
    logic [RCW-1:0] rc_q, rc_d;
    logic [GCW-1:0] gc_q, gc_d;
    logic [TOW-1:0] to_q, to_d;
    logic           start_q, edge_q;
    logic           done_q, done_d;
    logic           pass_q, pass_d;
    logic           fail_q, fail_d;
    logic [2:0]     err_q, err_d;
    logic [2:0]     err;
    logic           ok;
    logic           bump;
    logic           last;
    logic [3:0]     bc;

    counter_4b u_burst (
        .clk   (clk),
        .reset (reset),
        .clr_i (edge_q),
        .en_i  (bump),
        .cnt_o (bc)
    );

    assign last = ({1'b0, bc} + 5'd1) == 5'(N_BURSTS);

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        gc_d    = gc_q;
        to_d    = to_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        err_d   = err_q;
        err     = ERR_NONE;
        ok      = 1'b0;
        bump    = 1'b0;
        if (edge_q) begin
            state_d = S_ARMED;
            rc_d    = '0;
            gc_d    = '0;
            to_d    = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            err_d   = ERR_NONE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: ;
                S_ARMED: begin
                    to_d = to_q + 1'b1;
                    if (bist_end_in || (pulse_in && !running_in)) begin
                        err = ERR_PROTO;
                    end else if (pulse_in) begin
                        state_d = S_HIGH;
                        rc_d    = RC_ONE;
                    end else if (to_d == TO_LIM) begin
                        err = ERR_TIMEOUT;
                    end
                end
                S_HIGH: begin
                    if (pulse_in) begin
                        if (rc_q != RC_MAX) rc_d = rc_q + 1'b1;
                        if (!running_in) begin
                            err = ERR_PROTO;
                        end else if (rc_d == RC_MAX) begin
                            err = ERR_LONG;
                        end
                    end else if (rc_q < RC_MIN) begin
                        err = ERR_SHORT;
                    end else begin
                        bump = 1'b1;
                        // Final run must end with running low and bist_end high together
                        if (last) begin
                            if (!running_in && bist_end_in) ok = 1'b1;
                            else err = ERR_PROTO;
                        end else if (running_in && !bist_end_in) begin
                            state_d = S_LOW;
                            gc_d    = GC_ONE;
                        end else begin
                            err = ERR_PROTO;
                        end
                    end
                end
                S_LOW: begin
                    if (!running_in || bist_end_in) begin
                        err = ERR_PROTO;
                    end else if (!pulse_in) begin
                        if (gc_q != GC_MAX) gc_d = gc_q + 1'b1;
                        if (gc_d > GC_LIM) err = ERR_GAP;
                    end else if (gc_q != GC_LIM) begin
                        err = ERR_GAP;
                    end else begin
                        state_d = S_HIGH;
                        rc_d    = RC_ONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (ok) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                pass_d  = 1'b1;
            end
            if (err != ERR_NONE) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                fail_d  = 1'b1;
                err_d   = err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rc_q    <= '0;
            gc_q    <= '0;
            to_q    <= '0;
            start_q <= 1'b0;
            edge_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            gc_q    <= gc_d;
            to_q    <= to_d;
            start_q <= start;
            edge_q  <= start & ~start_q;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign err_code  = err_q;
    assign burst_cnt = bc;

endmodule

// File: tb/tb_pulse_checker.sv
// Directed self-checking bench for pulse_checker driving a modelled generator pattern.
`timescale 1ns/1ps
module tb_pulse_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       pulse_in;
    logic       running_in;
    logic       bist_end_in;
    logic       done;
    logic       pass;
    logic       fail;
    logic [2:0] err_code;
    logic [3:0] burst_cnt;

    int errors = 0;
    int checks = 0;

    pulse_checker dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pulse_in    (pulse_in),
        .running_in  (running_in),
        .bist_end_in (bist_end_in),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .err_code    (err_code),
        .burst_cnt   (burst_cnt)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic p, input logic r, input logic b);
        pulse_in    = p;
        running_in  = r;
        bist_end_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic high(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0);
    endtask

    task automatic low(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic outs(input string tag, input logic d, input logic p,
                        input logic f, input logic [2:0] e, input logic [3:0] bc);
        chk({tag, ".done"}, 8'(done), 8'(d));
        chk({tag, ".pass"}, 8'(pass), 8'(p));
        chk({tag, ".fail"}, 8'(fail), 8'(f));
        chk({tag, ".err"}, 8'(err_code), 8'(e));
        chk({tag, ".bcnt"}, 8'(burst_cnt), 8'(bc));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        outs("reset", 0, 0, 0, 3'd0, 4'd0);

        // Idle inputs are ignored without a start edge
        high(5);
        cyc(1'b0, 1'b0, 1'b1);
        chk("idle.done", 8'(done), 8'd0);

        // Full passing run
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
        do_start();
        for (int b = 1; b <= 9; b++) begin
            high(8);
            low(1);
        end
        high(8);
        outs("pass.pre", 0, 0, 0, 3'd0, 4'd9);
        cyc(1'b0, 1'b0, 1'b1);
        outs("pass", 1, 1, 0, 3'd0, 4'd10);
        cyc(1'b0, 1'b0, 1'b0);
        chk("pass.sticky", 8'(done & pass), 8'd1);

        // Third burst short
        do_start();
        outs("restart.clr", 0, 0, 0, 3'd0, 4'd0);
        high(8); low(1); high(8); low(1); high(7);
        cyc(1'b0, 1'b1, 1'b0);
        outs("short", 1, 0, 1, 3'd1, 4'd2);

        // Fifth burst long
        do_start();
        outs("restart2.clr", 0, 0, 0, 3'd0, 4'd0);
        for (int b = 0; b < 4; b++) begin
            high(8);
            low(1);
        end
        high(8);
        chk("long.pre", 8'(done), 8'd0);
        high(1);
        outs("long", 1, 0, 1, 3'd2, 4'd4);

        // Gap of two after burst one
        do_start();
        high(8); low(1);
        chk("gap.pre", 8'(done), 8'd0);
        low(1);
        outs("gap", 1, 0, 1, 3'd3, 4'd1);

        // Running stays high after the tenth burst
        do_start();
        for (int b = 0; b < 9; b++) begin
            high(8);
            low(1);
        end
        high(8);
        cyc(1'b0, 1'b1, 1'b0);
        outs("proto", 1, 0, 1, 3'd5, 4'd10);

        // Timeout
        do_start();
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("tmo.pre", 8'(done), 8'd0);
        cyc(1'b0, 1'b0, 1'b0);
        outs("tmo", 1, 0, 1, 3'd6, 4'd0);

        // Reset mid burst four
        do_start();
        for (int b = 0; b < 3; b++) begin
            high(8);
            low(1);
        end
        high(4);
        chk("rst.pre.bcnt", 8'(burst_cnt), 8'd3);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        outs("rst", 0, 0, 0, 3'd0, 4'd0);
        high(10);
        cyc(1'b0, 1'b0, 1'b1);
        chk("rst.idle.done", 8'(done), 8'd0);

        // New start edge mid burst aborts and re-arms
        do_start();
        high(8); low(1); high(3);
        chk("abort.pre.bcnt", 8'(burst_cnt), 8'd1);
        start = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        start = 1'b0;
        cyc(1'b1, 1'b1, 1'b0);
        outs("abort", 0, 0, 0, 3'd0, 4'd0);
        for (int b = 0; b < 9; b++) begin
            high(8);
            low(1);
        end
        high(8);
        cyc(1'b0, 1'b0, 1'b1);
        outs("abort.pass", 1, 1, 0, 3'd0, 4'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
